// File: rtl/sevenseg_capture_if.sv
// Bundle of the seven-segment bus being monitored plus the decoded results.
// The display driver / bench side uses master; the capture block uses slave.
interface sevenseg_capture_if;
   logic [6:0]  segments;
   logic [7:0]  anodes;
   logic        clear;
   logic [31:0] data_out;
   logic [7:0]  digit_valid;
   logic        frame_done;
   logic        pattern_error;
   logic        anode_error;

   modport master (
      output segments, anodes, clear,
      input  data_out, digit_valid, frame_done, pattern_error, anode_error
   );

   modport slave (
      input  segments, anodes, clear,
      output data_out, digit_valid, frame_done, pattern_error, anode_error
   );
endinterface

// File: rtl/sevenseg_capture.sv
// Decodes the multiplexed active-low 7-seg bus back into a 32-bit hex word with error flags.
// Latency: STABLE_CYCLES+1 edges from pins to outputs; passive monitor, no backpressure.
module sevenseg_capture #(
   parameter logic [7:0]  DIGIT_MASK    = 8'hC3,
   parameter int unsigned STABLE_CYCLES = 1
) (
   input logic               clock,
   input logic               reset,
   sevenseg_capture_if.slave bus
);

   localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

   logic [6:0]  seg_q, seg_d;
   logic [7:0]  an_q, an_d;
   logic [14:0] prev_q, prev_d;
   logic [3:0]  run_cnt_q, run_cnt_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  valid_q, valid_d;
   logic [7:0]  seen_q, seen_d;
   logic        frame_done_q, frame_done_d;
   logic        pattern_error_q, pattern_error_d;
   logic        anode_error_q, anode_error_d;

   logic [7:0]  an_low;
   logic        one_low;
   logic        multi_low;
   logic [2:0]  digit_idx;
   logic        same;
   logic        commit;
   logic [4:0]  dec;
   logic [7:0]  digit_bit;
   logic [7:0]  seen_next;

   // Returns {legal, nibble}; anything outside the 16 glyphs is illegal.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0000001: r = {1'b1, 4'h0};
         7'b1001111: r = {1'b1, 4'h1};
         7'b0010010: r = {1'b1, 4'h2};
         7'b0000110: r = {1'b1, 4'h3};
         7'b1001100: r = {1'b1, 4'h4};
         7'b0100100: r = {1'b1, 4'h5};
         7'b0100000: r = {1'b1, 4'h6};
         7'b0001111: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0000100: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b1100000: r = {1'b1, 4'hB};
         7'b0110001: r = {1'b1, 4'hC};
         7'b1000010: r = {1'b1, 4'hD};
         7'b0110000: r = {1'b1, 4'hE};
         7'b0111000: r = {1'b1, 4'hF};
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   always_comb begin
      an_low    = ~an_q;
      one_low   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
      multi_low = (an_low != 8'h00) && !one_low;
      digit_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (an_low[i]) digit_idx = 3'(i);
      end
      digit_bit = 8'h01 << digit_idx;
      dec       = seg_decode(seg_q);
      same      = ({seg_q, an_q} == prev_q);
   end

   // Run counter restarts on any change and parks at STAB so each run commits once.
   always_comb begin
      run_cnt_d = run_cnt_q;
      if (!one_low)
         run_cnt_d = 4'd0;
      else if (!same)
         run_cnt_d = 4'd1;
      else if (run_cnt_q < STAB)
         run_cnt_d = run_cnt_q + 4'd1;
      commit = one_low && (run_cnt_d == STAB) && (!same || (run_cnt_q != STAB));
   end

   always_comb begin
      seg_d           = bus.segments;
      an_d            = bus.anodes;
      prev_d          = {seg_q, an_q};
      data_d          = data_q;
      valid_d         = valid_q;
      seen_d          = seen_q;
      frame_done_d    = 1'b0;
      pattern_error_d = pattern_error_q;
      anode_error_d   = multi_low;
      seen_next       = seen_q | digit_bit;

      if (commit && DIGIT_MASK[digit_idx]) begin
         if (dec[4]) begin
            data_d[{digit_idx, 2'b00} +: 4] = dec[3:0];
            valid_d[digit_idx]              = 1'b1;
            if ((seen_next & DIGIT_MASK) == DIGIT_MASK) begin
               frame_done_d = 1'b1;
               seen_d       = 8'h00;
            end else begin
               seen_d = seen_next;
            end
         end else begin
            valid_d[digit_idx] = 1'b0;
            pattern_error_d    = 1'b1;
         end
      end

      if (bus.clear) begin
         data_d          = 32'h0;
         valid_d         = 8'h00;
         seen_d          = 8'h00;
         pattern_error_d = 1'b0;
         frame_done_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_q           <= 7'h7F;
         an_q            <= 8'hFF;
         prev_q          <= {7'h7F, 8'hFF};
         run_cnt_q       <= 4'd0;
         data_q          <= 32'h0;
         valid_q         <= 8'h00;
         seen_q          <= 8'h00;
         frame_done_q    <= 1'b0;
         pattern_error_q <= 1'b0;
         anode_error_q   <= 1'b0;
      end else begin
         seg_q           <= seg_d;
         an_q            <= an_d;
         prev_q          <= prev_d;
         run_cnt_q       <= bus.clear ? 4'd0 : run_cnt_d;
         data_q          <= data_d;
         valid_q         <= valid_d;
         seen_q          <= seen_d;
         frame_done_q    <= frame_done_d;
         pattern_error_q <= pattern_error_d;
         anode_error_q   <= anode_error_d;
      end
   end

   assign bus.data_out      = data_q;
   assign bus.digit_valid   = valid_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.pattern_error = pattern_error_q;
   assign bus.anode_error   = anode_error_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: one instance with STABLE_CYCLES=1 and one with 3, same stimulus.
// A history-based model predicts every output each cycle; literal checks pin the model.
module tb_sevenseg_capture;

   localparam logic [7:0] MASK  = 8'hC3;
   localparam int         STAB1 = 1;
   localparam int         STAB3 = 3;
   localparam logic [6:0] SEG_TBL [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sevenseg_capture_if bus1 ();
   sevenseg_capture_if bus3 ();

   sevenseg_capture #(.DIGIT_MASK(MASK), .STABLE_CYCLES(STAB1)) u_s1 (
      .clock(clock), .reset(reset), .bus(bus1));
   sevenseg_capture #(.DIGIT_MASK(MASK), .STABLE_CYCLES(STAB3)) u_s3 (
      .clock(clock), .reset(reset), .bus(bus3));

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   logic [31:0] m_data  [2];
   logic [7:0]  m_valid [2];
   logic [7:0]  m_seen  [2];
   logic        m_frame [2];
   logic        m_perr  [2];
   logic        m_aerr  [2];
   logic [14:0] hist [$];
   int          floor_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] lookup(input logic [6:0] p);
      for (int v = 0; v < 16; v++)
         if (SEG_TBL[v] == p) return {1'b1, 4'(v)};
      return 5'b0;
   endfunction

   function automatic int lows(input logic [7:0] an);
      int n = 0;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) n++;
      return n;
   endfunction

   function automatic int low_pos(input logic [7:0] an);
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) return i;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_data[k] = 32'h0; m_valid[k] = 8'h0; m_seen[k] = 8'h0;
         m_frame[k] = 1'b0; m_perr[k] = 1'b0; m_aerr[k] = 1'b0;
      end
      hist.delete();
      floor_idx = 0;
   endtask

   // A digit commits when the newest sample has been seen exactly STABLE times in a row.
   task automatic model_edge(input logic [6:0] sg, input logic [7:0] an, input logic clr);
      logic [14:0] last;
      logic [4:0]  dec;
      logic [7:0]  nxt;
      int          run_len, j, dig, stab;
      for (int k = 0; k < 2; k++) begin
         stab       = (k == 0) ? STAB1 : STAB3;
         m_frame[k] = 1'b0;
         m_aerr[k]  = 1'b0;
         if (hist.size() > 0) begin
            last    = hist[hist.size()-1];
            run_len = 0;
            j       = hist.size() - 1;
            while (j >= floor_idx && hist[j] == last) begin
               run_len++;
               j--;
            end
            m_aerr[k] = (lows(last[7:0]) >= 2);
            if (lows(last[7:0]) == 1 && run_len == stab && !clr) begin
               dig = low_pos(last[7:0]);
               dec = lookup(last[14:8]);
               if (MASK[dig]) begin
                  if (dec[4]) begin
                     m_data[k][dig*4 +: 4] = dec[3:0];
                     m_valid[k][dig] = 1'b1;
                     nxt = m_seen[k] | (8'h01 << dig);
                     if ((nxt & MASK) == MASK) begin
                        m_frame[k] = 1'b1;
                        m_seen[k]  = 8'h0;
                     end else begin
                        m_seen[k] = nxt;
                     end
                  end else begin
                     m_valid[k][dig] = 1'b0;
                     m_perr[k] = 1'b1;
                  end
               end
            end
         end
         if (clr) begin
            m_data[k] = 32'h0; m_valid[k] = 8'h0; m_seen[k] = 8'h0; m_perr[k] = 1'b0;
         end
      end
      if (clr) floor_idx = hist.size();
      hist.push_back({sg, an});
   endtask

   task automatic cyc(input logic [6:0] sg, input logic [7:0] an, input logic clr = 1'b0);
      bus1.segments = sg; bus3.segments = sg;
      bus1.anodes   = an; bus3.anodes   = an;
      bus1.clear    = clr; bus3.clear   = clr;
      @(posedge clock);
      if (reset) model_edge(sg, an, clr);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(7'h7F, 8'hFF);
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("s1_data",  bus1.data_out,             m_data[0]);
         chk("s1_valid", {24'h0, bus1.digit_valid}, {24'h0, m_valid[0]});
         chk("s1_frame", {31'h0, bus1.frame_done},  {31'h0, m_frame[0]});
         chk("s1_perr",  {31'h0, bus1.pattern_error}, {31'h0, m_perr[0]});
         chk("s1_aerr",  {31'h0, bus1.anode_error}, {31'h0, m_aerr[0]});
         chk("s3_data",  bus3.data_out,             m_data[1]);
         chk("s3_valid", {24'h0, bus3.digit_valid}, {24'h0, m_valid[1]});
         chk("s3_frame", {31'h0, bus3.frame_done},  {31'h0, m_frame[1]});
         chk("s3_perr",  {31'h0, bus3.pattern_error}, {31'h0, m_perr[1]});
         chk("s3_aerr",  {31'h0, bus3.anode_error}, {31'h0, m_aerr[1]});
      end
   end

   initial begin
      reset = 1'b1;
      bus1.segments = 7'h7F; bus3.segments = 7'h7F;
      bus1.anodes   = 8'hFF; bus3.anodes   = 8'hFF;
      bus1.clear    = 1'b0;  bus3.clear    = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("rst_data",  bus1.data_out, 32'h0);
      chk("rst_valid", {24'h0, bus1.digit_valid}, 32'h0);
      chk("rst_flags", {29'h0, bus1.frame_done, bus1.pattern_error, bus1.anode_error}, 32'h0);
      cmp_en = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      idle(2);

      // Frame capture: digits 0,1,6,7 = 3,5,A,C
      cyc(7'b0000110, 8'hFE);
      cyc(7'b0100100, 8'hFD);
      cyc(7'b0001000, 8'hBF);
      cyc(7'b0110001, 8'h7F);
      chk("t1_frame_early", {31'h0, bus1.frame_done}, 32'h0);
      idle(1);
      chk("t1_data",  bus1.data_out, 32'hCA000053);
      chk("t1_valid", {24'h0, bus1.digit_valid}, 32'h000000C3);
      chk("t1_frame", {31'h0, bus1.frame_done}, 32'h1);
      chk("t1_s3_data", bus3.data_out, 32'h0);
      idle(1);
      chk("t1_frame_once", {31'h0, bus1.frame_done}, 32'h0);

      // Illegal pattern on digit 1
      cyc(7'b1010101, 8'hFD);
      idle(1);
      chk("t3_perr",  {31'h0, bus1.pattern_error}, 32'h1);
      chk("t3_valid", {24'h0, bus1.digit_valid}, 32'h000000C1);
      chk("t3_data",  bus1.data_out, 32'hCA000053);
      chk("t3_frame", {31'h0, bus1.frame_done}, 32'h0);
      idle(2);
      chk("t3_sticky", {31'h0, bus1.pattern_error}, 32'h1);

      // Two anodes low, then blank
      cyc(7'b0000000, 8'hFC);
      idle(1);
      chk("t4_aerr", {31'h0, bus1.anode_error}, 32'h1);
      chk("t4_data", bus1.data_out, 32'hCA000053);
      idle(1);
      chk("t4_aerr_pulse", {31'h0, bus1.anode_error}, 32'h0);

      // Masked-out digit 4
      cyc(7'b0000000, 8'hEF);
      idle(1);
      chk("t5_data",  bus1.data_out, 32'hCA000053);
      chk("t5_valid", {24'h0, bus1.digit_valid}, 32'h000000C1);
      chk("t5_flags", {30'h0, bus1.frame_done, bus1.anode_error}, 32'h0);

      // Stability filter on the STABLE_CYCLES=3 instance
      cyc(7'h7F, 8'hFF, 1'b1);
      cyc(7'b1001111, 8'hFE);
      cyc(7'b1001111, 8'hFE);
      idle(3);
      chk("t2_short_data",  bus3.data_out, 32'h0);
      chk("t2_short_valid", {24'h0, bus3.digit_valid}, 32'h0);
      cyc(7'b1001111, 8'hFE);
      cyc(7'b1001111, 8'hFE);
      cyc(7'b1001111, 8'hFE);
      chk("t2_not_yet", {24'h0, bus3.digit_valid}, 32'h0);
      idle(1);
      chk("t2_data",  bus3.data_out, 32'h00000001);
      chk("t2_valid", {24'h0, bus3.digit_valid}, 32'h00000001);

      // Clear on the same edge as the frame-completing commit
      cyc(7'b0100100, 8'hFD);
      cyc(7'b0001000, 8'hBF);
      cyc(7'b0110001, 8'h7F);
      cyc(7'h7F, 8'hFF, 1'b1);
      chk("t6_clr_data",  bus1.data_out, 32'h0);
      chk("t6_clr_valid", {24'h0, bus1.digit_valid}, 32'h0);
      chk("t6_clr_frame", {31'h0, bus1.frame_done}, 32'h0);
      idle(1);
      chk("t6_clr_frame2", {31'h0, bus1.frame_done}, 32'h0);

      // Asynchronous reset in the middle of a frame
      cyc(7'b0000110, 8'hFE);
      cyc(7'b1010101, 8'hFD);
      cyc(7'b0000000, 8'hFC);
      chk("t6_pre_data", bus1.data_out, 32'h00000003);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_data",  bus1.data_out, 32'h0);
      chk("t6_rst_valid", {24'h0, bus1.digit_valid}, 32'h0);
      chk("t6_rst_perr",  {31'h0, bus1.pattern_error}, 32'h0);
      chk("t6_rst_aerr",  {31'h0, bus1.anode_error}, 32'h0);
      chk("t6_rst_s3",    bus3.data_out, 32'h0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      idle(3);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
Monitor and decoder for the multiplexed 8-digit, active-low seven-segment bus on the Nexys A7. It samples segments and anodes every clock and inverts the one-cold anode scan and the segment encoding. It rebuilds the displayed 32-bit hex word, one nibble per digit, and flags illegal bus states. It serves as the scoreboard front-end for display-path testbenches and as on-board loopback checking for the display driver.

Parameters:
DIGIT_MASK, 8'hC3, digits that are captured (bit i = AN i). The default covers AN0, AN1, AN6, AN7; other digits are ignored.
STABLE_CYCLES, 1, consecutive identical samples needed before a digit commits (legal values 1..15).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
segments  input  7  {CA,CB,CC,CD,CE,CF,CG}; 0 = segment lit
anodes  input  8  {AN7..AN0}; 0 = digit enabled (one-cold)
clear  input  1  synchronous clear of captured state, active-high
data_out  output  32  captured word; nibble i = data_out[4i+3:4i] = digit i
digit_valid  output  8  bit i set = nibble i holds a legally decoded value
frame_done  output  1  one-cycle pulse when every DIGIT_MASK digit has committed since the last frame
pattern_error  output  1  sticky flag: an illegal segment pattern was committed
anode_error  output  1  one-cycle pulse: a sample had more than one anode low

Behaviour:
- Input stage: segments and anodes are registered every edge into seg_q and an_q. No synchronizer; the inputs are assumed synchronous to clock.
- Anode decode of an_q:
  - Exactly one bit low gives digit index i.
  - All ones means blank; no commit, and the run counter resets.
  - Two or more bits low: anode_error pulses on the next edge, no commit, and the run counter resets.
- Stability filter:
  - run_cnt increments while {seg_q, an_q} equals the previous cycle's value.
  - On any change, run_cnt reloads to 1. It saturates at STABLE_CYCLES.
  - A commit fires once per run, on the edge where run_cnt reaches STABLE_CYCLES.
  - Latency: inputs held constant from edge k are visible on the outputs after edge k+STABLE_CYCLES.
- Segment decode, inverse table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern, including all-off 1111111, is illegal.
- Commit to digit i when DIGIT_MASK[i]=1:
  - Legal pattern: nibble i gets the decoded value, digit_valid[i] is set to 1, seen[i] is set to 1.
  - Illegal pattern: nibble i is retained, digit_valid[i] is cleared, pattern_error is set, seen[i] is unchanged.
- Commit to digit i when DIGIT_MASK[i]=0: ignored entirely, no flags.
- Frame tracking:
  - After a legal commit, if (seen | commit bit) & DIGIT_MASK == DIGIT_MASK, frame_done is 1 for exactly that cycle and seen clears to 0.
  - Recommitting a digit already seen does not pulse frame_done.
- clear=1: on the next edge, data_out, digit_valid, seen, pattern_error and run_cnt are zeroed. clear overrides a commit in the same cycle, and frame_done stays 0.
- Reset low, asynchronous and immediate:
  - data_out=0, digit_valid=0, frame_done=0, pattern_error=0, anode_error=0, seen=0, run_cnt=0.
  - seg_q=7'h7F and an_q=8'hFF (blank).
  - Deassertion takes effect at the next rising edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Frame capture: reset, STABLE_CYCLES=1. Drive one cycle each of (an=FE, seg=0000110), (FD, 0100100), (BF, 0001000), (7F, 0110001). Expect data_out=32'hCA000053, digit_valid=8'hC3, and frame_done high for exactly one cycle, one edge after the last sample is captured.
2. Stability: STABLE_CYCLES=3. Hold (FE, 1001111) for 2 cycles then change; expect no update. Hold it for 3 cycles; expect nibble 0=1 and digit_valid[0]=1 after the 3rd edge following capture.
3. Illegal pattern: after test 1, drive (FD, 1010101). Expect pattern_error=1 sticky, digit_valid[1]=0, nibble 1 still 5, and no frame_done.
4. Anode faults: drive an=FC with any segments; expect a one-cycle anode_error and data_out unchanged. Drive an=FF; expect no commit and no error.
5. Mask: drive (EF, 0000000); expect data_out[19:16]=0, digit_valid[4]=0, and no flags.
6. Reset and clear: assert reset mid-frame; expect all outputs 0 immediately, with no clock edge. Separately, assert clear in the same cycle as a completing commit; expect all zeros and frame_done=0.
